regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter
// Purpose: buffers one ALU and one MEM writeback request each and issues
//   at most one register-file write per cycle, using round-robin between
//   requesters and age order when both target the same register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   halt_sys                 stop accepting and issuing while high
//   alu_valid/ready/addr/long/data   ALU writeback request channel
//   mem_valid/ready/addr/data        load writeback request channel
//   write_en, R0_en, write_address, write_data   registered write port
//   pending                  one bit per register with a buffered write
//   commit_cnt               wrapping count of issued writes
module regfile_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_sys,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [3:0]       alu_addr,
  input  logic             alu_long,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [3:0]       mem_addr,
  input  logic [15:0]      mem_data,
  output logic             write_en,
  output logic             R0_en,
  output logic [3:0]       write_address,
  output logic [31:0]      write_data,
  output logic [15:0]      pending,
  output logic [CNT_W-1:0] commit_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              alu_v_q, alu_v_d;
  logic [3:0]        alu_addr_q, alu_addr_d;
  logic              alu_long_q, alu_long_d;
  logic [31:0]       alu_data_q, alu_data_d;
  logic              alu_age_q, alu_age_d;
  logic              mem_v_q, mem_v_d;
  logic [3:0]        mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic              mem_age_q, mem_age_d;
  logic              last_alu_q, last_alu_d;
  logic              write_en_q, write_en_d;
  logic              r0_en_q, r0_en_d;
  logic [3:0]        write_address_q, write_address_d;
  logic [31:0]       write_data_q, write_data_d;
  logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;

  logic halted, alu_acc, mem_acc, both, conflict, pick_alu, issue;
  logic grant_alu, grant_mem, alu_stay, mem_stay;

  always_comb begin
    // halt_sys gates the same cycle it rises, so an edge that moves the
    // FSM into HALTED never issues or accepts.
    halted    = (state_q == HALTED) || halt_sys;
    state_d   = halt_sys ? HALTED : RUN;
    alu_acc   = alu_valid && !alu_v_q && !halted;
    mem_acc   = mem_valid && !mem_v_q && !halted;

    both      = alu_v_q && mem_v_q;
    conflict  = (alu_addr_q == mem_addr_q) || (alu_long_q && (mem_addr_q == 4'd0));
    if (both) pick_alu = conflict ? alu_age_q : !last_alu_q;
    else      pick_alu = alu_v_q;
    issue     = !halted && (alu_v_q || mem_v_q);
    grant_alu = issue && pick_alu;
    grant_mem = issue && !pick_alu;
    alu_stay  = alu_v_q && !grant_alu;
    mem_stay  = mem_v_q && !grant_mem;

    alu_v_d    = alu_v_q;
    alu_addr_d = alu_addr_q;
    alu_long_d = alu_long_q;
    alu_data_d = alu_data_q;
    alu_age_d  = alu_age_q;
    mem_v_d    = mem_v_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_age_d  = mem_age_q;
    last_alu_d = last_alu_q;

    if (grant_alu) begin
      alu_v_d   = 1'b0;
      alu_age_d = 1'b0;
    end
    if (grant_mem) begin
      mem_v_d   = 1'b0;
      mem_age_d = 1'b0;
    end
    if (both && issue) last_alu_d = grant_alu;

    // Age bit set marks the older of two coexisting entries; a same-edge
    // pair orders ALU before MEM.
    if (alu_acc) begin
      alu_v_d    = 1'b1;
      alu_addr_d = alu_addr;
      alu_long_d = alu_long;
      alu_data_d = alu_data;
      alu_age_d  = !mem_stay;
      if (mem_stay) mem_age_d = 1'b1;
    end
    if (mem_acc) begin
      mem_v_d    = 1'b1;
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;
      mem_age_d  = !(alu_stay || alu_acc);
      if (alu_stay) alu_age_d = 1'b1;
    end

    write_en_d      = issue;
    r0_en_d         = grant_alu && alu_long_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    commit_cnt_d    = commit_cnt_q;
    if (issue) begin
      write_address_d = grant_alu ? alu_addr_q : mem_addr_q;
      write_data_d    = grant_alu ? alu_data_q : {16'h0000, mem_data_q};
      commit_cnt_d    = commit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    pending = 16'h0000;
    if (alu_v_q) pending[alu_addr_q] = 1'b1;
    if (alu_v_q && alu_long_q) pending[0] = 1'b1;
    if (mem_v_q) pending[mem_addr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      alu_v_q         <= 1'b0;
      alu_addr_q      <= 4'd0;
      alu_long_q      <= 1'b0;
      alu_data_q      <= 32'd0;
      alu_age_q       <= 1'b0;
      mem_v_q         <= 1'b0;
      mem_addr_q      <= 4'd0;
      mem_data_q      <= 16'd0;
      mem_age_q       <= 1'b0;
      last_alu_q      <= 1'b0;
      write_en_q      <= 1'b0;
      r0_en_q         <= 1'b0;
      write_address_q <= 4'd0;
      write_data_q    <= 32'd0;
      commit_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      alu_v_q         <= alu_v_d;
      alu_addr_q      <= alu_addr_d;
      alu_long_q      <= alu_long_d;
      alu_data_q      <= alu_data_d;
      alu_age_q       <= alu_age_d;
      mem_v_q         <= mem_v_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_age_q       <= mem_age_d;
      last_alu_q      <= last_alu_d;
      write_en_q      <= write_en_d;
      r0_en_q         <= r0_en_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      commit_cnt_q    <= commit_cnt_d;
    end
  end

  assign alu_ready     = !alu_v_q && !halted;
  assign mem_ready     = !mem_v_q && !halted;
  assign write_en      = write_en_q;
  assign R0_en         = r0_en_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign commit_cnt    = commit_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_sys = 1'b0;
  logic        alu_valid = 1'b0, alu_long = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_addr = 4'd0, mem_addr = 4'd0;
  logic [31:0] alu_data = 32'd0;
  logic [15:0] mem_data = 16'd0;

  logic        alu_ready, mem_ready, write_en, R0_en;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic [15:0] pending, commit_cnt;

  logic        alu_ready4, mem_ready4, write_en4, r0_en4;
  logic [3:0]  write_address4;
  logic [31:0] write_data4;
  logic [15:0] pending4;
  logic [3:0]  commit_cnt4;

  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [3:0] first_addr;
  logic [3:0] exp_first, exp_second;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_long(alu_long), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data),
    .write_en(write_en), .R0_en(R0_en), .write_address(write_address),
    .write_data(write_data), .pending(pending), .commit_cnt(commit_cnt)
  );

  regfile_write_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .alu_valid(alu_valid), .alu_ready(alu_ready4), .alu_addr(alu_addr),
    .alu_long(alu_long), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready4), .mem_addr(mem_addr),
    .mem_data(mem_data),
    .write_en(write_en4), .R0_en(r0_en4), .write_address(write_address4),
    .write_data(write_data4), .pending(pending4), .commit_cnt(commit_cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents the requests for one edge; returns at the negedge after it.
  task automatic load(input logic av, input logic [3:0] aa, input logic al,
                      input logic [31:0] ad, input logic mv, input logic [3:0] ma,
                      input logic [15:0] md);
    alu_valid = av; alu_addr = aa; alu_long = al; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_write_en", write_en, 0);
    chk("rst_r0_en", R0_en, 0);
    chk("rst_pending", pending, 0);
    chk("rst_commit", commit_cnt, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", write_data, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single ALU write, two-edge latency
    load(1, 4'd5, 0, 32'h0000_1234, 0, 4'd0, 16'h0);
    chk("t1_pending", pending, 32'h0020);
    chk("t1_alu_ready", alu_ready, 0);
    chk("t1_we_early", write_en, 0);
    @(negedge clk);
    chk("t1_we", write_en, 1);
    chk("t1_addr", write_address, 5);
    chk("t1_data", write_data, 32'h0000_1234);
    chk("t1_r0", R0_en, 0);
    chk("t1_commit", commit_cnt, 1);
    @(negedge clk);
    chk("t1_we_drop", write_en, 0);
    chk("t1_addr_hold", write_address, 5);

    // Long ALU write also claims R0
    load(1, 4'd3, 1, 32'hAAAA_5555, 0, 4'd0, 16'h0);
    chk("t2_pending", pending, 32'h0009);
    @(negedge clk);
    chk("t2_we", write_en, 1);
    chk("t2_r0", R0_en, 1);
    chk("t2_addr", write_address, 3);
    chk("t2_data", write_data, 32'hAAAA_5555);
    chk("t2_pending_clr", pending, 0);

    // Same-edge pairs without conflict: first winner alternates
    for (int i = 0; i < 4; i++) begin
      load(1, 4'd2, 0, 32'h100 + i, 1, 4'd7, 16'h200 + 16'(i));
      chk("rr_pending", pending, 32'h0084);
      exp_first  = (i % 2 == 0) ? 4'd2 : 4'd7;
      exp_second = (i % 2 == 0) ? 4'd7 : 4'd2;
      @(negedge clk);
      chk("rr_first_we", write_en, 1);
      chk("rr_first_addr", write_address, exp_first);
      @(negedge clk);
      chk("rr_second_we", write_en, 1);
      chk("rr_second_addr", write_address, exp_second);
      chk("rr_second_data", write_data, (exp_second == 4'd2) ? 32'h100 + i : 32'h200 + i);
      @(negedge clk);
    end
    chk("rr_commit", commit_cnt, 10);

    // MEM to R0 then ALU long on the next edge
    load(0, 4'd0, 0, 32'h0, 1, 4'd0, 16'hBEEF);
    load(1, 4'd4, 1, 32'h1234_5678, 0, 4'd0, 16'h0);
    chk("t4_mem_we", write_en, 1);
    chk("t4_mem_addr", write_address, 0);
    chk("t4_mem_data", write_data, 32'h0000_BEEF);
    chk("t4_mem_r0", R0_en, 0);
    chk("t4_pending", pending, 32'h0011);
    @(negedge clk);
    chk("t4_alu_addr", write_address, 4);
    chk("t4_alu_r0", R0_en, 1);
    chk("t4_alu_data", write_data, 32'h1234_5678);
    chk("t4_commit", commit_cnt, 12);
    @(negedge clk);

    // Non-conflicting pair: ALU wins, so round robin now favours MEM
    load(1, 4'd8, 0, 32'h8, 1, 4'd9, 16'h9);
    @(negedge clk);
    chk("t5_first", write_address, 8);
    @(negedge clk);
    chk("t5_second", write_address, 9);
    @(negedge clk);

    // Long ALU vs MEM to R0: conflict, the older ALU wins over round robin
    load(1, 4'd5, 1, 32'hCAFE_0001, 1, 4'd0, 16'h0002);
    chk("cf_pending", pending, 32'h0021);
    @(negedge clk);
    chk("cf_first_addr", write_address, 5);
    chk("cf_first_r0", R0_en, 1);
    @(negedge clk);
    chk("cf_second_addr", write_address, 0);
    chk("cf_second_data", write_data, 32'h0000_0002);
    chk("cf_second_r0", R0_en, 0);
    @(negedge clk);

    // Halt with both buffers full
    load(1, 4'd10, 0, 32'hA, 1, 4'd11, 16'hB);
    halt_sys = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_we", write_en, 0);
      chk("halt_alu_ready", alu_ready, 0);
      chk("halt_mem_ready", mem_ready, 0);
    end
    chk("halt_pending", pending, 32'h0C00);
    halt_sys = 1'b0;
    @(negedge clk);
    chk("unhalt_we0", write_en, 0);
    @(negedge clk);
    chk("unhalt_we1", write_en, 1);
    first_addr = write_address;
    @(negedge clk);
    chk("unhalt_we2", write_en, 1);
    chk("unhalt_sum", 32'(first_addr) + 32'(write_address), 21);
    chk("unhalt_distinct", (first_addr != write_address), 1);
    chk("unhalt_commit", commit_cnt, 18);
    @(negedge clk);

    // Reset mid-operation drops both buffered requests
    load(1, 4'd1, 0, 32'h1, 1, 4'd2, 16'h2);
    rst = 1'b1;
    #1;
    chk("mrst_pending", pending, 0);
    chk("mrst_we", write_en, 0);
    chk("mrst_commit", commit_cnt, 0);
    chk("mrst_alu_ready", alu_ready, 1);
    chk("mrst_mem_ready", mem_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_write", write_en, 0);
    end
    chk("mrst_commit_after", commit_cnt, 0);

    // 17 writes: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      load(1, 4'(i), 0, 32'(i), 0, 4'd0, 16'h0);
      @(negedge clk);
    end
    chk("cnt16_17", commit_cnt, 17);
    chk("cnt4_wrap", commit_cnt4, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
